// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle between the ALU issue controller, its upstream issuer,
// the execute-stage ALU and the downstream writeback consumer.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_ctrl;
  logic [31:0]      in_srcA;
  logic [31:0]      in_srcB;
  logic [TAG_W-1:0] in_tag;

  logic [3:0]       alu_ctrl;
  logic [31:0]      alu_srcA;
  logic [31:0]      alu_srcB;
  logic [31:0]      alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_ctrl, in_srcA, in_srcB, in_tag, alu_result, out_ready,
    output in_ready, alu_ctrl, alu_srcA, alu_srcB,
           out_valid, out_result, out_tag, out_err, busy
  );

  modport master (
    output in_valid, in_ctrl, in_srcA, in_srcB, in_tag, alu_result, out_ready,
    input  in_ready, alu_ctrl, alu_srcA, alu_srcB,
           out_valid, out_result, out_tag, out_err, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller for the execute-stage ALU: registers one op into the
// ALU, waits out the FP adder latency, and queues tagged results toward writeback.
module alu_issue_ctrl #(
  parameter int FP_LAT = 3,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_issue_ctrl_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
  localparam logic [3:0] OP_FADD = 4'd2;

  typedef enum logic [1:0] {IDLE, EXEC, FP_WAIT} state_e;

  typedef struct packed {
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } entry_t;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [31:0]      src_a_q, src_a_d;
  logic [31:0]      src_b_q, src_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           fifo_mem [DEPTH];
  entry_t           head;

  logic             fp_op, legal_op;
  logic             in_ready, out_valid, accept, push, pop;
  logic [CNT_W:0]   occupancy;

  assign fp_op    = (bus.in_ctrl == OP_FADD);
  assign legal_op = (bus.in_ctrl == 4'd1) || (bus.in_ctrl >= 4'd4 && bus.in_ctrl <= 4'd9);

  // An op sitting in the ALU already owns a FIFO slot, so it counts toward fullness.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q != IDLE)};
  assign in_ready  = (state_q != FP_WAIT) && (occupancy < (CNT_W+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign push      = (state_q == EXEC) || (state_q == FP_WAIT && lat_cnt_q == '0);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    alu_ctrl_d = alu_ctrl_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    tag_d      = tag_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: ;
      EXEC: begin
        state_d    = IDLE;
        alu_ctrl_d = 4'd0;
      end
      FP_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d    = IDLE;
          alu_ctrl_d = 4'd0;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE/EXEC, so it overrides the EXEC retirement above.
    if (accept) begin
      state_d    = fp_op ? FP_WAIT : EXEC;
      lat_cnt_d  = LAT_W'(FP_LAT - 1);
      alu_ctrl_d = (fp_op || legal_op) ? bus.in_ctrl : 4'd0;
      err_d      = !(fp_op || legal_op);
      src_a_d    = bus.in_srcA;
      src_b_d    = bus.in_srcB;
      tag_d      = bus.in_tag;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      alu_ctrl_q <= 4'd0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      alu_ctrl_q <= alu_ctrl_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is not reset; the head outputs are masked by out_valid instead.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{err: err_q, tag: tag_q, res: bus.alu_result};
    end
  end

  assign head = fifo_mem[rd_ptr_q];

  assign bus.in_ready   = in_ready;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_srcA   = src_a_q;
  assign bus.alu_srcB   = src_b_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_valid ? head.res : '0;
  assign bus.out_tag    = out_valid ? head.tag : '0;
  assign bus.out_err    = out_valid && head.err;
  assign bus.busy       = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the far side of the controller,
// a queue-based reference of accepted ops, directed cases then random traffic.
module tb_alu_issue_ctrl;

  localparam int FP_LAT = 3;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(.FP_LAT(FP_LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- float helpers (normal numbers, truncating) ----------------
  function automatic real f32_to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ---------------- ALU environment: combinational, FP adder clocked ----------------
  logic [31:0] fp_s0, fp_s1;
  always @(posedge clock) begin
    fp_s0 <= real_to_f32(f32_to_real(bus.alu_srcA) + f32_to_real(bus.alu_srcB));
    fp_s1 <= fp_s0;
  end

  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_ctrl)
      4'd1: bus.alu_result = bus.alu_srcA + bus.alu_srcB;
      4'd2: bus.alu_result = fp_s1;
      4'd4: bus.alu_result = bus.alu_srcA << bus.alu_srcB[4:0];
      4'd5: bus.alu_result = bus.alu_srcA >> bus.alu_srcB[4:0];
      4'd6: bus.alu_result = bus.alu_srcA | bus.alu_srcB;
      4'd7: bus.alu_result = bus.alu_srcA & bus.alu_srcB;
      4'd8: bus.alu_result = bus.alu_srcA ^ bus.alu_srcB;
      4'd9: bus.alu_result = bus.alu_srcA ^ 32'h8000_0000;
      default: bus.alu_result = 32'd0;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   fp_pending;
  int   checks;
  int   failures;
  logic last_acc;

  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd1: return a + b;
      4'd2: return real_to_f32(f32_to_real(a) + f32_to_real(b));
      4'd4: return a << b[4:0];
      4'd5: return a >> b[4:0];
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return a ^ b;
      4'd9: return real_to_f32(-f32_to_real(a));
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // One clock: observe handshakes mid-cycle, update the model, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    check("busy", 32'(bus.busy), 32'(sb.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(fp_pending == 0 && sb.size() < DEPTH));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("pop_when_empty", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_result", bus.out_result, e.res);
        check("out_tag", 32'(bus.out_tag), 32'(e.tag));
        check("out_err", 32'(bus.out_err), 32'(e.err));
      end
    end
    if (fp_pending > 0) fp_pending--;
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) begin
      sb.push_back('{res: ref_result(bus.in_ctrl, bus.in_srcA, bus.in_srcB),
                     tag: bus.in_tag,
                     err: !(bus.in_ctrl inside {4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9})});
      if (bus.in_ctrl == 4'd2) fp_pending = FP_LAT;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_srcA  = a;
    bus.in_srcB  = b;
    bus.in_tag   = t;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = last_acc;
    end
    if (!done) check("send_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.busy); i++) tick();
    check("drain_left", sb.size(), 32'd0);
    check("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;

    checks = 0; failures = 0; fp_pending = 0; last_acc = 1'b0;
    bus.in_valid = 1'b0; bus.in_ctrl = 4'd0; bus.in_srcA = '0; bus.in_srcB = '0;
    bus.in_tag = '0; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    #22 reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset state
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_srcA", bus.alu_srcA, 32'd0);
    check("rst_srcB", bus.alu_srcB, 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single int add: visible at the head one cycle after the execute edge
    send(4'd1, 32'd5, 32'd7, 5'd3);
    tick();
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_result", bus.out_result, 32'd12);
    check("add_tag", 32'(bus.out_tag), 32'd3);
    check("add_err", 32'(bus.out_err), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("add_busy_clear", 32'(bus.busy), 32'd0);

    // Back-to-back logic/shift ops while draining
    send(4'd7, 32'h0000_F0F0, 32'h0000_00FF, 5'd4);
    send(4'd8, 32'h0000_000A, 32'h0000_0006, 5'd5);
    send(4'd4, 32'h0000_0001, 32'h0000_0004, 5'd6);
    drain();

    // FP add 1.0 + 2.0: controller holds ALU inputs for the full latency
    bus.out_ready = 1'b0;
    send(4'd2, 32'h3F80_0000, 32'h4000_0000, 5'd7);
    for (int i = 0; i < FP_LAT; i++) begin
      check("fp_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      check("fp_hold_srcA", bus.alu_srcA, 32'h3F80_0000);
      tick();
    end
    check("fp_valid", 32'(bus.out_valid), 32'd1);
    check("fp_result", bus.out_result, 32'h4040_0000);
    send(4'd2, real_to_f32(4.0), real_to_f32(8.0), 5'd8);
    drain();

    // Fill: three queued plus one executing stalls the input
    bus.out_ready = 1'b0;
    send(4'd6, 32'h0000_0100, 32'h0000_0001, 5'd9);
    send(4'd5, 32'h8000_0000, 32'd31, 5'd10);
    send(4'd1, 32'hFFFF_FFFF, 32'd2, 5'd11);
    send(4'd9, real_to_f32(3.0), 32'd0, 5'd12);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    drain();

    // Illegal codes yield 0 with the error flag
    bus.out_ready = 1'b0;
    send(4'd3, 32'd11, 32'd22, 5'd1);
    send(4'hF, 32'd33, 32'd44, 5'd2);
    check("ill_result", bus.out_result, 32'd0);
    check("ill_err", 32'(bus.out_err), 32'd1);
    check("ill_tag", 32'(bus.out_tag), 32'd1);
    drain();

    // Reset while an FP op is in flight with two results queued
    bus.out_ready = 1'b0;
    send(4'd1, 32'd1, 32'd1, 5'd20);
    send(4'd1, 32'd2, 32'd2, 5'd21);
    send(4'd2, real_to_f32(5.0), real_to_f32(6.0), 5'd22);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    sb.delete();
    fp_pending = 0;
    @(negedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) tick();

    // Random traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (c == 4'd2 || c == 4'd9) begin
        a = real_to_f32($itor($urandom_range(1, 1000)));
        b = real_to_f32($itor($urandom_range(1, 1000)));
      end
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_ctrl   = c;
      bus.in_srcA   = a;
      bus.in_srcB   = b;
      bus.in_tag    = TAG_W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/collect controller that sits in front of the execute-stage ALU: accepts tagged operations over a valid/ready handshake, drives the ALU's control and operand inputs from registers, waits out the multi-cycle floating-point add pipeline, and returns tagged results through a small output FIFO toward writeback. It is the producer/consumer counterpart to the ALU. The ALU itself stays combinational except for its clocked FP adder.

## Interface
- FP_LAT, 3: clock edges from FP op issue to valid FP result at alu_result (>=1)
- TAG_W, 5: width of the op tag carried alongside each operation
- DEPTH, 4: output FIFO entries (power of two, >=2)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept an op this cycle
- in_ctrl  in  4  ALU op code (1 int add, 2 fp add, 4 shl, 5 shr, 6 or, 7 and, 8 xor, 9 fneg)
- in_srcA / in_srcB  in  32 each  operands
- in_tag  in  TAG_W  op tag
- alu_ctrl  out  4  registered control to ALU
- alu_srcA / alu_srcB  out  32 each  registered operands to ALU
- alu_result  in  32  ALU result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_result  out  32  head result
- out_tag  out  TAG_W  head tag
- out_err  out  1  head op had illegal code
- busy  out  1  op in flight or FIFO non-empty

## Operation
- FSM states: IDLE, EXEC (single-cycle op in ALU), FP_WAIT (FP op in flight).
- Accept = in_valid & in_ready at a rising edge; in_ctrl/in_srcA/in_srcB/in_tag latched into alu_* and a tag/err register.
- Codes 1,4-9 legal single-cycle -> EXEC. Code 2 -> FP_WAIT, counter loaded FP_LAT-1. Codes 0,3,A-F illegal: treated as single-cycle, alu_ctrl forced to 0 (ALU returns 0), err bit set.
- EXEC: alu_result pushed to FIFO (with tag, err) at the next edge; a new op may be accepted on that same edge (back-to-back); otherwise return to IDLE and alu_ctrl cleared to 0.
- FP_WAIT: alu_ctrl held at 2 and operands held; counter decrements each edge; on the edge where counter is 0, alu_result pushed, state -> IDLE. No accept while in FP_WAIT.
- in_ready = (state IDLE or EXEC) & (fifo_count + (state != IDLE) < DEPTH), so FIFO can never overflow.
- FIFO: pop on out_valid & out_ready; push and pop on same edge leave count unchanged; pointers wrap modulo DEPTH; order strictly preserved.
- busy = (state != IDLE) | (fifo_count != 0).

## Timing
- Reset (async, immediate): state IDLE, FIFO empty, alu_ctrl=0, alu_srcA/B=0, out_valid=0, out_result/out_tag/out_err=0, busy=0; in_ready=1 once reset_n high.
- Int op accepted at edge N: result in FIFO after edge N+1; out_valid high in cycle after N+1 if FIFO was empty. Throughput 1 op/cycle while FIFO drains.
- FP op accepted at edge N: pushed at edge N+FP_LAT; in_ready low from after edge N until after edge N+FP_LAT (FP_LAT=1 gives same timing as int op but still blocks accept on edge N+1).
- out_* are registered FIFO-head outputs; stable while out_valid & !out_ready.
- reset_n asserted mid-operation discards in-flight op and FIFO contents; no result emitted.

## Test plan
- Reset, then accept ctrl=1 srcA=5 srcB=7 tag=3 -> one cycle after next edge out_valid=1, out_result=12, out_tag=3, out_err=0; busy clears after pop.
- Back-to-back ctrl=7 (0xF0F0 & 0x00FF), ctrl=8 (0xA ^ 0x6), ctrl=4 (1<<4), out_ready=1 -> results 0x00F0, 0xC, 0x10 on consecutive cycles, tags in order, in_ready never drops.
- ctrl=2 with 1.0 (0x3F800000) + 2.0 (0x40000000), FP_LAT=3 -> in_ready low 3 cycles, alu_ctrl held 2, out_result=0x40400000.
- out_ready=0, issue 4 int ops -> in_ready deasserts with 4 entries (3 queued + 1 in EXEC counts); raise out_ready -> 4 results in order, no loss or duplicate, full-to-empty wrap correct.
- ctrl=3 and ctrl=0xF with tags 1,2 -> out_result=0, out_err=1 for both.
- Assert reset_n low during FP_WAIT with 2 FIFO entries -> out_valid=0, busy=0 immediately, in_ready=1 after release, no stale result emitted.
